dds_status_tx: RTL and testbench

// - Transmit side of the DDS ASCII control protocol: serialises a frequency/waveform setting into the exact byte

---
 rtl/dds_uart_pkg.sv | 44 ++++
 rtl/dds_status_tx_if.sv | 24 ++
 rtl/dds_status_tx_bin2bcd_seq.sv | 57 +++++
 rtl/dds_status_tx.sv | 136 +++++++++++++
 tb/tb_dds_status_tx.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dds_uart_pkg.sv
// Shared definitions for the DDS ASCII status transmitter: ASCII byte
// constants, wave_sel encodings, transmit FSM states and small char helpers.
// Optional macro DDS_STATUS_CRLF_EN adds the CR/LF trailer states.
package dds_uart_pkg;

    localparam logic [7:0] CH_S      = 8'h73;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_SINE   = 8'h61;
    localparam logic [7:0] CH_SQUARE = 8'h63;
    localparam logic [7:0] CH_TRI    = 8'h62;

    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_SEND_WAVE,
        ST_SEND_DIG,
        ST_SEND_S,
`ifdef DDS_STATUS_CRLF_EN
        ST_SEND_CR,
        ST_SEND_LF,
`endif
        ST_DONE
    } tx_state_e;

    // Receiver mapping: 'a' sine, 'c' square, 'b' triangle; code 3 falls back to sine.
    function automatic logic [7:0] wave_char(input logic [1:0] ws);
        case (ws)
            WAVE_SQUARE: wave_char = CH_SQUARE;
            WAVE_TRI:    wave_char = CH_TRI;
            default:     wave_char = CH_SINE;
        endcase
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] nib);
        digit_char = CH_ZERO + {4'h0, nib};
    endfunction

endpackage

// File: rtl/dds_status_tx_if.sv
// Bus between DDS control logic (master) and the status transmitter (slave).
// Byte handshake: a byte moves on a rising clk edge where tx_valid && tx_ready;
// while tx_valid is high and not yet accepted, tx_data holds and tx_valid stays
// high; a new byte may be offered the cycle after acceptance.
interface dds_status_tx_if #(parameter int FREQ_W = 32);
    logic              start;
    logic [FREQ_W-1:0] freq_hz;
    logic [1:0]        wave_sel;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, freq_hz, wave_sel, tx_ready,
        input  tx_data, tx_valid, busy, done
    );

    modport slave (
        input  start, freq_hz, wave_sel, tx_ready,
        output tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/dds_status_tx_bin2bcd_seq.sv
// Sequential double-dabble: load captures the binary value, then FREQ_W cycles
// each add 3 to every nibble >= 5 and shift one bit in. done pulses for one
// cycle when the BCD result becomes final; bcd holds until the next load.
module bin2bcd_seq #(
    parameter int FREQ_W = 32,
    parameter int NDIG   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [FREQ_W-1:0]     bin,
    output logic                  busy,
    output logic                  done,
    output logic [NDIG-1:0][3:0]  bcd
);
    localparam int CW = $clog2(FREQ_W + 1);

    logic [FREQ_W-1:0]    sh;
    logic [CW-1:0]        cnt;
    logic [NDIG-1:0][3:0] adj;
    logic [4*NDIG:0]      shifted;

    // Add-3 correction on every digit ahead of the shift.
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            adj[i] = (bcd[i] >= 4'd5) ? bcd[i] + 4'd3 : bcd[i];
        end
        shifted = {adj, sh[FREQ_W-1]};
    end

    // One shift per cycle while busy; the top shifted-out bit is always zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            cnt  <= '0;
            bcd  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                sh   <= bin;
                bcd  <= '0;
                cnt  <= CW'(FREQ_W);
                busy <= 1'b1;
            end else if (busy) begin
                bcd <= shifted[4*NDIG-1:0];
                sh  <= {sh[FREQ_W-2:0], 1'b0};
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/dds_status_tx.sv
// DDS status transmitter: on start, captures frequency/waveform and emits
// <wave char><decimal Hz, no leading zeros>'s' over a valid/ready byte port.
// Macro DDS_STATUS_CRLF_EN appends CR LF after 's' for terminal viewing.
module dds_status_tx
    import dds_uart_pkg::*;
#(
    parameter int FREQ_W = 32,
    parameter int NDIG   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dds_status_tx_if.slave         bus,
    output tx_state_e              dbg_state
);
    localparam int PW = $clog2(NDIG);

    tx_state_e            state;
    logic [1:0]           wave_q;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        ptr_nxt;
    logic [PW-1:0]        lead;
    logic                 conv_load;
    logic                 conv_busy;
    logic                 conv_done;
    logic [NDIG-1:0][3:0] conv_bcd;
    logic                 hs;

    assign conv_load = (state == ST_IDLE) && bus.start;
    assign hs        = bus.tx_valid && bus.tx_ready;
    assign ptr_nxt   = ptr - PW'(1);
    assign dbg_state = state;

    bin2bcd_seq #(.FREQ_W(FREQ_W), .NDIG(NDIG)) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (conv_load),
        .bin   (bus.freq_hz),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Highest nonzero digit index; zero when the value is zero so a lone '0' is sent.
    always_comb begin
        lead = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (conv_bcd[i] != 4'd0) lead = PW'(i);
        end
    end

    // Transmit FSM with registered byte, valid, busy and done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wave_q       <= '0;
            ptr          <= '0;
            bus.tx_data  <= 8'h00;
            bus.tx_valid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        wave_q   <= bus.wave_sel;
                        bus.busy <= 1'b1;
                        state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    // Engine idle with a fresh result: leading digit is known now.
                    if (conv_done && !conv_busy) begin
                        ptr          <= lead;
                        bus.tx_data  <= wave_char(wave_q);
                        bus.tx_valid <= 1'b1;
                        state        <= ST_SEND_WAVE;
                    end
                end
                ST_SEND_WAVE: begin
                    if (hs) begin
                        bus.tx_data <= digit_char(conv_bcd[ptr]);
                        state       <= ST_SEND_DIG;
                    end
                end
                ST_SEND_DIG: begin
                    if (hs) begin
                        if (ptr == '0) begin
                            bus.tx_data <= CH_S;
                            state       <= ST_SEND_S;
                        end else begin
                            ptr         <= ptr_nxt;
                            bus.tx_data <= digit_char(conv_bcd[ptr_nxt]);
                        end
                    end
                end
`ifdef DDS_STATUS_CRLF_EN
                ST_SEND_S: begin
                    if (hs) begin
                        bus.tx_data <= CH_CR;
                        state       <= ST_SEND_CR;
                    end
                end
                ST_SEND_CR: begin
                    if (hs) begin
                        bus.tx_data <= CH_LF;
                        state       <= ST_SEND_LF;
                    end
                end
                ST_SEND_LF: begin
                    if (hs) begin
                        bus.tx_valid <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
`else
                ST_SEND_S: begin
                    if (hs) begin
                        bus.tx_valid <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    bus.done <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_status_tx.sv
// Bench for dds_status_tx: randomized reports checked against a decimal-string
// reference model, with ready throttling, stalls, ignored starts and mid-report reset.
module tb_dds_status_tx;
    import dds_uart_pkg::*;

    logic      clk;
    logic      rst_n;
    tx_state_e dbg_state;
    int        n_tests = 0;
    int        n_fail  = 0;
    int        rdy_mode = 0;   // 0 always ready, 1 random 50%, 2 held low
    logic [7:0] exp_q[$];

    dds_status_tx_if #(.FREQ_W(32)) bus ();

    dds_status_tx #(.FREQ_W(32), .NDIG(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream straight from the protocol: wave char, decimal Hz, 's'.
    task automatic push_expected(input logic [31:0] f, input logic [1:0] w);
        logic [7:0] d[$];
        longint     v;
        case (w)
            2'd1:    exp_q.push_back(8'h63);
            2'd2:    exp_q.push_back(8'h62);
            default: exp_q.push_back(8'h61);
        endcase
        v = longint'(f);
        if (v == 0) d.push_back(8'h30);
        while (v > 0) begin
            d.push_front(8'(v % 10) + 8'h30);
            v = v / 10;
        end
        foreach (d[i]) exp_q.push_back(d[i]);
        exp_q.push_back(8'h73);
`ifdef DDS_STATUS_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // Ready driver
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.tx_ready = 1'($urandom_range(0, 1));
                2:       bus.tx_ready = 1'b0;
                default: bus.tx_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard / handshake monitor
    initial begin
        bit         stall_prev = 0;
        logic [7:0] prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", 32'(bus.tx_valid), 32'd1);
                    chk("hold_data", 32'(bus.tx_data), 32'(prev_data));
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) chk("extra_byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
                    else chk("byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                end
                stall_prev = bus.tx_valid && !bus.tx_ready;
                prev_data  = bus.tx_data;
            end
        end
    end

    task automatic run_report(input logic [31:0] f, input logic [1:0] w, input int mode,
                              input bit mid_start, input bit done_start, input bit hold_low);
        int n;
        bit busy_gap = 0;
        bit got_done = 0;
        rdy_mode = mode;
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.freq_hz  = f;
        bus.wave_sel = w;
        push_expected(f, w);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.freq_hz  = $urandom;
        bus.wave_sel = 2'($urandom_range(0, 3));
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) busy_gap = 1;
            if (bus.tx_valid) begin
                n = i;
                break;
            end
        end
        chk("first_valid_latency", 32'(n), 32'd33);
        if (hold_low) begin
            repeat (40) @(posedge clk);
            #1;
            chk("stall_valid", 32'(bus.tx_valid), 32'd1);
            chk("stall_state", 32'(dbg_state), 32'(ST_SEND_WAVE));
            rdy_mode = 0;
        end
        if (mid_start) begin
            repeat (2) @(posedge clk);
            #1;
            bus.start    = 1'b1;
            bus.freq_hz  = $urandom;
            bus.wave_sel = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got_done = 1;
                break;
            end
            if (!bus.busy) busy_gap = 1;
        end
        chk("done_seen", 32'(got_done), 32'd1);
        chk("busy_continuous", 32'(busy_gap), 32'd0);
        chk("busy_low_at_done", 32'(bus.busy), 32'd0);
        chk("valid_low_at_done", 32'(bus.tx_valid), 32'd0);
        chk("all_bytes_sent", 32'(exp_q.size()), 32'd0);
        if (done_start) begin
            bus.start   = 1'b1;
            bus.freq_hz = $urandom;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("idle_after_done", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        chk("start_in_done_ignored", 32'(bus.busy), 32'd0);
        exp_q.delete();
        rdy_mode = 0;
    endtask

    // Main sequence
    initial begin
        bit seen;
        bus.start    = 1'b0;
        bus.freq_hz  = '0;
        bus.wave_sel = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;

        run_report(32'd1000, 2'd0, 0, 0, 0, 0);
        run_report(32'd0, 2'd2, 0, 0, 0, 0);
        run_report(32'hFFFF_FFFF, 2'd1, 0, 0, 0, 0);
        run_report(32'd85899, 2'd0, 1, 0, 0, 0);
        run_report(32'd3000, 2'd3, 0, 1, 1, 0);
        run_report(32'd123, 2'd1, 2, 0, 0, 1);
        run_report(32'd50, 2'd0, 0, 0, 0, 0);

        // Reset in the middle of the digit phase
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.freq_hz  = 32'd85899;
        bus.wave_sel = 2'd1;
        push_expected(32'd85899, 2'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.tx_valid) begin
                seen = 1;
                break;
            end
        end
        chk("rst_test_valid_seen", 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_test_in_digits", 32'(dbg_state), 32'(ST_SEND_DIG));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_report(32'd777, 2'd2, 1, 0, 0, 0);

        // Randomized reports
        for (int k = 0; k < 8; k++) begin
            logic [31:0] f;
            f = $urandom >> $urandom_range(0, 31);
            run_report(f, 2'($urandom_range(0, 3)), $urandom_range(0, 1), 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
